// File: rtl/conv_pkg.sv
// conv_pkg -- shared types and constants for the convolution sequencer.
//   conv_seq_state_t : 4-bit FSM state encoding
//   MIN_IFMAP_WIDTH  : smallest ifmap side that yields at least one window
//   KERNEL_WIDTH     : convolution kernel side
package conv_pkg;

   localparam int MIN_IFMAP_WIDTH = 3;
   localparam int KERNEL_WIDTH    = 3;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_START   = 4'd2,
      S_COMPUTE = 4'd3,
      S_DONE    = 4'd4
   } conv_seq_state_t;

   // Number of valid KxK windows along one side of a WxW ifmap.
   function automatic logic [31:0] out_side(input logic [31:0] w);
      return w - 32'(KERNEL_WIDTH - 1);
   endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if -- pixel stream and buffer-router bus of the sequencer.
//   s_data/s_valid/s_ready       : ifmap pixel stream (row-major)
//   rtr_wr_data/addr/en          : router write port
//   rtr_start, rtr_done          : router compute start pulse / last-pixel flag
//   out_valid, out_idx           : window valid and its row-major ofmap index
// Handshake: a pixel transfers on a rising clk edge where s_valid and s_ready
// are both high; s_valid low is a stall, s_ready low means no transfer.
// Modports: slave = sequencer side, master = environment (source + router).
interface conv_sequencer_if #(
   parameter int dataSize = 8,
   parameter int nAddress = 8
);
   logic [dataSize-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   logic [dataSize-1:0] rtr_wr_data;
   logic [nAddress-1:0] rtr_wr_addr;
   logic                rtr_wr_en;
   logic                rtr_start;
   logic                rtr_done;
   logic                out_valid;
   logic [15:0]         out_idx;

   modport slave (
      input  s_data, s_valid, rtr_done,
      output s_ready, rtr_wr_data, rtr_wr_addr, rtr_wr_en,
             rtr_start, out_valid, out_idx
   );

   modport master (
      output s_data, s_valid, rtr_done,
      input  s_ready, rtr_wr_data, rtr_wr_addr, rtr_wr_en,
             rtr_start, out_valid, out_idx
   );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer -- loads a square ifmap into the buffer router, kicks off
// the router, and tracks the ofmap window index until the router finishes.
//   clk, nrst        : clock (rising edge), asynchronous active-low reset
//   cfg_ifmap_width  : ifmap side W, sampled when a job is accepted
//   ctrl_start       : job request, honoured only in S_IDLE
//   busy             : high in every state except S_IDLE
//   flag_done        : one-cycle job-complete pulse
//   err_cfg, err_seq : one-cycle error pulses (bad config / router sequence)
//   dbg_state        : current FSM state
//   bus              : pixel stream + router port (slave modport)
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int dataSize    = 8,
   parameter int numRegister = 256
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [15:0]     cfg_ifmap_width,
   input  logic            ctrl_start,
   output logic            busy,
   output logic            flag_done,
   output logic            err_cfg,
   output logic            err_seq,
   output conv_seq_state_t dbg_state,
   conv_sequencer_if.slave bus
);

   localparam int nAddress = $clog2(numRegister);

   conv_seq_state_t     state;
   logic [nAddress-1:0] load_cnt;
   logic [15:0]         out_cnt;
   logic [31:0]         npix_m1;
   logic [31:0]         nout_m1;
   logic                err_cfg_q;

   // Job sizing in 32-bit arithmetic so a wide W cannot wrap into range.
   logic [31:0] w32, npix_c, nout_c;
   logic        cfg_ok;
   assign w32    = {16'd0, cfg_ifmap_width};
   assign npix_c = w32 * w32;
   assign nout_c = out_side(w32) * out_side(w32);
   assign cfg_ok = (w32 >= 32'(MIN_IFMAP_WIDTH)) && (npix_c <= 32'(numRegister));

   logic wr_fire, load_last, out_last, in_compute;
   assign wr_fire    = (state == S_LOAD) && bus.s_valid;
   assign load_last  = (32'(load_cnt) == npix_m1);
   assign out_last   = (32'(out_cnt) == nout_m1);
   assign in_compute = (state == S_COMPUTE);

   // Writes pass straight through in the handshake cycle; payloads are
   // forced to zero whenever their qualifier is low.
   assign bus.s_ready     = (state == S_LOAD);
   assign bus.rtr_wr_en   = wr_fire;
   assign bus.rtr_wr_data = wr_fire ? bus.s_data : {dataSize{1'b0}};
   assign bus.rtr_wr_addr = wr_fire ? load_cnt : {nAddress{1'b0}};
   assign bus.rtr_start   = (state == S_START);
   assign bus.out_valid   = in_compute;
   assign bus.out_idx     = in_compute ? out_cnt : 16'd0;

   // err_seq fires when rtr_done and "last window" disagree: an early done,
   // or reaching the last window without done (watchdog).
   assign err_seq   = in_compute && (bus.rtr_done != out_last);
   assign flag_done = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign err_cfg   = err_cfg_q;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         load_cnt  <= '0;
         out_cnt   <= '0;
         npix_m1   <= '0;
         nout_m1   <= '0;
         err_cfg_q <= 1'b0;
      end else begin
         err_cfg_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ctrl_start) begin
                  if (cfg_ok) begin
                     npix_m1  <= npix_c - 32'd1;
                     nout_m1  <= nout_c - 32'd1;
                     load_cnt <= '0;
                     out_cnt  <= '0;
                     state    <= S_LOAD;
                  end else begin
                     err_cfg_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.s_valid) begin
                  if (load_last) begin
                     load_cnt <= '0;
                     state    <= S_START;
                  end else begin
                     load_cnt <= load_cnt + nAddress'(1);
                  end
               end
            end
            S_START: begin
               out_cnt <= '0;
               state   <= S_COMPUTE;
            end
            S_COMPUTE: begin
               if (bus.rtr_done || out_last) begin
                  out_cnt <= '0;
                  state   <= S_DONE;
               end else begin
                  out_cnt <= out_cnt + 16'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
